seg_scan_ctrl: RTL

- Parametrised, time-multiplexed N-digit seven-segment display controller for the board I/O interface.
- Holds one 5-bit display code plus one decimal-point bit per digit, written by the CPU-side I/O decoder.
- Scans the digits with a prescaled counter and drives shared active-low segment lines and per-digit active-low anodes.
- Adds inter-digit ghost blanking and per-digit blink on top of the existing hex-glyph decoding.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_glyph_dec.sv | 13 +
 rtl/seg_scan_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and glyph lookup for the seven-segment scan controller.
// Glyphs are active-low, bit6 = g down to bit0 = a.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int         CODE_W    = 5;

    localparam logic [6:0] GLYPH_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Code bit4 selects between showing the low nibble as hex and a dark digit.
    function automatic logic [6:0] code_to_glyph(input logic [CODE_W-1:0] code);
        logic [6:0] glyph;
        if (code[CODE_W-1]) begin
            glyph = GLYPH_TAB[code[3:0]];
        end else begin
            glyph = SEG_BLANK;
        end
        return glyph;
    endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational display-code to active-low segment decoder.
module seg_glyph_dec
    import seg_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic [6:0]        o_seg_n
);

    always_comb begin
        o_seg_n = code_to_glyph(i_code);
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment controller: digit register file,
// slot prescaler, digit scan, ghost blanking, per-digit blink and registered outputs.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYC    = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter int AW           = $clog2(DIGITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [4:0]        wr_code,
    input  logic              wr_dp,
    input  logic [DIGITS-1:0] blink_mask,
    output logic [6:0]        seg_n,
    output logic              dp_n,
    output logic [DIGITS-1:0] an_n,
    output logic              frame_tick
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]     BLANK_END  = PW'(BLANK_CYC);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [FW-1:0]     FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [DIGITS-1:0] AN_ONE     = {{(DIGITS-1){1'b0}}, 1'b1};

    logic [CODE_W-1:0] r_code [DIGITS];
    logic [DIGITS-1:0] r_dp;

    logic [PW-1:0]     r_presc;
    logic [IW-1:0]     r_idx;
    logic [FW-1:0]     r_frame_cnt;
    logic              r_blink_ph;

    logic [6:0]        r_seg_n;
    logic              r_dp_n;
    logic [DIGITS-1:0] r_an_n;
    logic              r_frame_tick;

    logic              w_slot_end;
    logic              w_last_digit;
    logic              w_frame_wrap;
    logic              w_in_blank;
    logic [CODE_W-1:0] w_cur_code;
    logic              w_cur_dp;
    logic              w_cur_blink;
    logic              w_blink_off;
    logic [6:0]        w_glyph;
    logic [DIGITS-1:0] w_an_onehot;

    // Addresses at or beyond DIGITS match no entry, so such writes fall away.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < DIGITS; d++) begin
                r_code[d] <= '0;
            end
            r_dp <= '0;
        end else if (wr_en) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (32'(wr_addr) == d) begin
                    r_code[d] <= wr_code;
                    r_dp[d]   <= wr_dp;
                end
            end
        end
    end

    assign w_slot_end   = (r_presc == PRESC_LAST);
    assign w_last_digit = (r_idx == IDX_LAST);
    assign w_frame_wrap = w_slot_end & w_last_digit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_slot_end) begin
            r_presc <= '0;
            r_idx   <= w_last_digit ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // The phase flips on the same edge that raises frame_tick for the last counted frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (w_frame_wrap) begin
            if (r_frame_cnt == FRAME_LAST) begin
                r_frame_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_cur_code  = r_code[r_idx];
    assign w_cur_dp    = r_dp[r_idx];
    assign w_cur_blink = blink_mask[r_idx];
    assign w_blink_off = r_blink_ph & w_cur_blink;
    assign w_in_blank  = (r_presc < BLANK_END);
    assign w_an_onehot = AN_ONE << r_idx;

    seg_glyph_dec u_glyph_dec (
        .i_code  (w_cur_code),
        .o_seg_n (w_glyph)
    );

    // Segments keep driving during the blank window; only the anodes go dark.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_n      <= SEG_BLANK;
            r_dp_n       <= 1'b1;
            r_an_n       <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg_n      <= w_blink_off ? SEG_BLANK : w_glyph;
            r_dp_n       <= ~(w_cur_dp & w_cur_code[CODE_W-1] & ~w_blink_off);
            r_an_n       <= w_in_blank ? '1 : ~w_an_onehot;
            r_frame_tick <= w_frame_wrap;
        end
    end

    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign an_n       = r_an_n;
    assign frame_tick = r_frame_tick;

endmodule
